// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state type and width helper. Pure declarations: no latency,
// no flow control. The top module honours the BCD_DIGIT_CHECK_EN macro.
package bcd_pkg;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] ADJ_THR = DIG_W'(8);
  localparam logic [DIG_W-1:0] ADJ_OFF = DIG_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest value an n-digit BCD number can hold (10^n - 1).
  function automatic int max_bcd(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_dig_adj.sv
// Reverse double-dabble digit correction: subtract 3 when the shifted digit is >= 8.
// Combinational, zero latency, no flow control.
module bcd_dig_adj
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] dig,
  output logic [DIG_W-1:0] adj
);

  assign adj = (dig >= ADJ_THR) ? dig - ADJ_OFF : dig;

endmodule

// File: rtl/bcd_to_bin_conv.sv
// Sequential BCD-to-binary converter (reverse double-dabble); done pulses 11 cycles after start,
// start ignored while busy/DONE. BCD_DIGIT_CHECK_EN adds invalid-digit detection on err.
module bcd_to_bin_conv
  import bcd_pkg::*;
#(
  parameter int N_DIG = 3,
  parameter int BIN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       in_CEN,
  input  logic [3:0]       in_DEC,
  input  logic [3:0]       in_UND,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] out_BIN,
  output logic             err
);

  localparam int BCD_W = N_DIG * DIG_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if ((64'd1 << BIN_W) <= 64'(max_bcd(N_DIG))) begin : g_bad_width
    $error("BIN_W too narrow for N_DIG digits");
  end

  state_t           state;
  logic [BCD_W-1:0] bcd_reg;
  logic [BIN_W-1:0] bin_reg;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_in;
  logic [BCD_W-1:0] bcd_shr;
  logic [BCD_W-1:0] bcd_adj;

  assign bcd_in  = BCD_W'({in_CEN, in_DEC, in_UND});
  assign bcd_shr = bcd_reg >> 1;

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .dig (bcd_shr[g*DIG_W +: DIG_W]),
      .adj (bcd_adj[g*DIG_W +: DIG_W])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic digit_bad;
  logic err_pend;

  assign digit_bad = (in_CEN > 4'd9) || (in_DEC > 4'd9) || (in_UND > 4'd9);

  // Invalid entries skip CONV; bin_reg stays cleared so out_BIN reads 0 with err set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_BIN  <= '0;
      err      <= 1'b0;
      err_pend <= 1'b0;
      bcd_reg  <= '0;
      bin_reg  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bcd_reg  <= bcd_in;
          bin_reg  <= '0;
          cnt      <= '0;
          err_pend <= digit_bad;
          busy     <= !digit_bad;
          state    <= digit_bad ? DONE : CONV;
        end
        CONV: begin
          bcd_reg <= bcd_adj;
          bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          out_BIN <= bin_reg;
          err     <= err_pend;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      out_BIN <= '0;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bcd_reg <= bcd_in;
          bin_reg <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          bcd_reg <= bcd_adj;
          bin_reg <= {bcd_reg[0], bin_reg[BIN_W-1:1]};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          out_BIN <= bin_reg;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
